legv8_imm_decode_stage: RTL



---
 rtl/legv8_imm_pkg.sv | 55 +++++
 rtl/legv8_imm_extract.sv | 83 ++++++++
 rtl/legv8_imm_decode_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/legv8_imm_pkg.sv
// legv8_imm_pkg
// Shared constants for the LEGv8 immediate-decode stage: the format tag
// encodings, the opcode patterns that select each instruction format, and the
// datapath widths.
//
// Build option: IMM_BRANCH_SHL2_EN (consumed by legv8_imm_extract) turns the
// B/CB word offsets into byte offsets.

package legv8_imm_pkg;

  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;

  // Format tags carried alongside the immediate.
  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_D  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_CB = 3'd4;
  localparam logic [2:0] FMT_IW = 3'd5;

  // B format, instr[31:26]
  localparam logic [5:0] OP_B  = 6'b000101;
  localparam logic [5:0] OP_BL = 6'b100101;

  // CB format, instr[31:24]
  localparam logic [7:0] OP_CBZ   = 8'b10110100;
  localparam logic [7:0] OP_CBNZ  = 8'b10110101;
  localparam logic [7:0] OP_BCOND = 8'b01010100;

  // D format, instr[31:21]
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_LDURB  = 11'b00111000010;
  localparam logic [10:0] OP_STURB  = 11'b00111000000;
  localparam logic [10:0] OP_LDURH  = 11'b01111000010;
  localparam logic [10:0] OP_STURH  = 11'b01111000000;
  localparam logic [10:0] OP_LDURSW = 11'b10111000100;
  localparam logic [10:0] OP_STURW  = 11'b10111000000;

  // IW format, instr[31:23]
  localparam logic [8:0] OP_MOVZ = 9'b110100101;
  localparam logic [8:0] OP_MOVK = 9'b111100101;

  // I format, instr[31:22]
  localparam logic [9:0] OP_ADDI  = 10'b1001000100;
  localparam logic [9:0] OP_ADDIS = 10'b1011000100;
  localparam logic [9:0] OP_SUBI  = 10'b1101000100;
  localparam logic [9:0] OP_SUBIS = 10'b1111000100;
  localparam logic [9:0] OP_ANDI  = 10'b1001001000;
  localparam logic [9:0] OP_ORRI  = 10'b1011001000;
  localparam logic [9:0] OP_EORI  = 10'b1101001000;
  localparam logic [9:0] OP_ANDIS = 10'b1111001000;

endpackage

// File: rtl/legv8_imm_extract.sv
// legv8_imm_extract
// Purely combinational format classifier and immediate generator.
//
// Ports:
//   instr  in   INSTR_W  instruction word
//   imm    out  DATA_W   extended immediate (0 for R format)
//   fmt    out  3        format tag (FMT_R..FMT_IW)
//
// Build option: IMM_BRANCH_SHL2_EN -- when defined, B and CB immediates are
// shifted left by 2 after sign extension (byte offset); otherwise the word
// offset is passed through and the branch adder does the shift.

import legv8_imm_pkg::*;

module legv8_imm_extract #(
  parameter int DATA_W  = legv8_imm_pkg::DATA_W,
  parameter int INSTR_W = legv8_imm_pkg::INSTR_W
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  imm,
  output logic [2:0]         fmt
);

  logic [5:0]  op_b;
  logic [7:0]  op_cb;
  logic [10:0] op_d;
  logic [8:0]  op_iw;
  logic [9:0]  op_i;

  logic [DATA_W-1:0] imm_b;
  logic [DATA_W-1:0] imm_cb;
  logic [DATA_W-1:0] imm_d;
  logic [DATA_W-1:0] imm_iw;
  logic [DATA_W-1:0] imm_i;

  assign op_b  = instr[31:26];
  assign op_cb = instr[31:24];
  assign op_d  = instr[31:21];
  assign op_iw = instr[31:23];
  assign op_i  = instr[31:22];

  assign imm_d  = {{(DATA_W-9){instr[20]}}, instr[20:12]};
  assign imm_i  = {{(DATA_W-12){1'b0}}, instr[21:10]};
  // MOVZ/MOVK: imm16 placed at halfword position hw (shift = hw*16).
  assign imm_iw = {{(DATA_W-16){1'b0}}, instr[20:5]} << {instr[22:21], 4'b0000};

`ifdef IMM_BRANCH_SHL2_EN
  assign imm_b  = {{(DATA_W-28){instr[25]}}, instr[25:0], 2'b00};
  assign imm_cb = {{(DATA_W-21){instr[23]}}, instr[23:5], 2'b00};
`else
  assign imm_b  = {{(DATA_W-26){instr[25]}}, instr[25:0]};
  assign imm_cb = {{(DATA_W-19){instr[23]}}, instr[23:5]};
`endif

  // Priority order matters: the first matching format wins.
  always_comb begin
    imm = '0;
    fmt = FMT_R;
    if (op_b == OP_B || op_b == OP_BL) begin
      imm = imm_b;
      fmt = FMT_B;
    end else if (op_cb == OP_CBZ || op_cb == OP_CBNZ || op_cb == OP_BCOND) begin
      imm = imm_cb;
      fmt = FMT_CB;
    end else if (op_d == OP_LDUR  || op_d == OP_STUR  ||
                 op_d == OP_LDURB || op_d == OP_STURB ||
                 op_d == OP_LDURH || op_d == OP_STURH ||
                 op_d == OP_LDURSW || op_d == OP_STURW) begin
      imm = imm_d;
      fmt = FMT_D;
    end else if (op_iw == OP_MOVZ || op_iw == OP_MOVK) begin
      imm = imm_iw;
      fmt = FMT_IW;
    end else if (op_i == OP_ADDI || op_i == OP_ADDIS ||
                 op_i == OP_SUBI || op_i == OP_SUBIS ||
                 op_i == OP_ANDI || op_i == OP_ORRI  ||
                 op_i == OP_EORI || op_i == OP_ANDIS) begin
      imm = imm_i;
      fmt = FMT_I;
    end
  end

endmodule

// File: rtl/legv8_imm_decode_stage.sv
// legv8_imm_decode_stage
// Pipelined immediate-generation stage between IF/ID and EX. Decodes the
// instruction format and immediate, and registers imm/fmt/pc behind a
// valid/ready handshake with a one-entry skid buffer (two entries total).
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   flush                synchronous kill of every held entry
//   in_valid/in_ready    upstream handshake; in_instr, in_pc payload
//   out_valid/out_ready  downstream handshake; out_imm, out_fmt, out_pc payload
//
// Handshake: a beat transfers on a cycle where valid and ready are both high.
// Once out_valid is high it stays high with a stable payload until out_ready
// is seen. in_ready is !skid_valid, so it depends only on registered state.
//
// Build option: IMM_BRANCH_SHL2_EN (see legv8_imm_extract).

import legv8_imm_pkg::*;

module legv8_imm_decode_stage #(
  parameter int DATA_W  = legv8_imm_pkg::DATA_W,
  parameter int INSTR_W = legv8_imm_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_imm,
  output logic [2:0]         out_fmt,
  output logic [DATA_W-1:0]  out_pc
);

  logic [DATA_W-1:0] dec_imm;
  logic [2:0]        dec_fmt;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_imm;
  logic [2:0]        skid_fmt;
  logic [DATA_W-1:0] skid_pc;

  logic in_fire;
  logic out_hold;

  legv8_imm_extract #(
    .DATA_W  (DATA_W),
    .INSTR_W (INSTR_W)
  ) u_extract (
    .instr (in_instr),
    .imm   (dec_imm),
    .fmt   (dec_fmt)
  );

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_hold = out_valid && !out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_fmt    <= FMT_R;
      out_pc     <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_fmt   <= FMT_R;
      skid_pc    <= '0;
    end else if (flush) begin
      // Payload registers keep stale data; only the valid bits matter.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // in_ready is low here, so nothing new arrives; only drain skid to out.
      if (out_ready) begin
        out_imm    <= skid_imm;
        out_fmt    <= skid_fmt;
        out_pc     <= skid_pc;
        skid_valid <= 1'b0;
      end
    end else if (out_hold) begin
      // Out is stalled: park the new beat so upstream sees no back-pressure
      // combinationally from out_ready.
      if (in_fire) begin
        skid_imm   <= dec_imm;
        skid_fmt   <= dec_fmt;
        skid_pc    <= in_pc;
        skid_valid <= 1'b1;
      end
    end else begin
      // Out empty or draining this cycle: the new beat goes straight to out.
      if (in_fire) begin
        out_imm   <= dec_imm;
        out_fmt   <= dec_fmt;
        out_pc    <= in_pc;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
